// File: rtl/gry_cnt_if.sv
// Control and status bundle for the binary/Gray up-down counter.
// master drives the controls and observes the count; slave is the counter.
interface gry_cnt_if #(
  parameter int N = 8
);
  logic         en;
  logic         up_dn;
  logic         load;
  logic [N-1:0] load_val;
  logic [N-1:0] binary;
  logic [N-1:0] gray;
  logic         at_max;
  logic         at_min;
  logic         wrap;

  modport master (
    output en, up_dn, load, load_val,
    input  binary, gray, at_max, at_min, wrap
  );

  modport slave (
    input  en, up_dn, load, load_val,
    output binary, gray, at_max, at_min, wrap
  );
endinterface

// File: rtl/gry_cnt.sv
// Up/down binary counter with same-edge registered Gray output, load, and wrap/saturate ends.
// Latency 1 cycle (load > step > hold); no backpressure, en is a level strobe giving one step per edge.
module gry_cnt #(
  parameter int N    = 8,
  parameter bit WRAP = 1'b1
) (
  input logic       clk,
  input logic       rst_n,
  gry_cnt_if.slave  cnt
);

  localparam logic [N-1:0] MAX_VAL = '1;
  localparam logic [N-1:0] MIN_VAL = '0;
  localparam logic [N-1:0] ONE     = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] bin_q, bin_d;
  logic [N-1:0] gray_q, gray_d;
  logic         wrap_q, wrap_d;

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (cnt.load) begin
      bin_d = cnt.load_val;
    end else if (cnt.en) begin
      if (cnt.up_dn) begin
        if (bin_q == MAX_VAL) begin
          if (WRAP) begin
            bin_d  = MIN_VAL;
            wrap_d = 1'b1;
          end
        end else begin
          bin_d = bin_q + ONE;
        end
      end else begin
        if (bin_q == MIN_VAL) begin
          if (WRAP) begin
            bin_d  = MAX_VAL;
            wrap_d = 1'b1;
          end
        end else begin
          bin_d = bin_q - ONE;
        end
      end
    end
    // Encode from the next binary value so both registers update on the same edge.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign cnt.binary = bin_q;
  assign cnt.gray   = gray_q;
  assign cnt.wrap   = wrap_q;
  assign cnt.at_max = (bin_q == MAX_VAL);
  assign cnt.at_min = (bin_q == MIN_VAL);

endmodule

// File: tb/tb_gry_cnt.sv
// Bench for gry_cnt: four instances (N4 wrap, N4 saturate, N8 wrap, N5 saturate) share one control stream.
// Directed steps with known constants, then random traffic against an arithmetic reference model.
module tb_gry_cnt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        up_dn = 1'b0;
  logic        load = 1'b0;
  logic [31:0] lv = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  gry_cnt_if #(.N(4)) i4w ();
  gry_cnt_if #(.N(4)) i4s ();
  gry_cnt_if #(.N(8)) i8 ();
  gry_cnt_if #(.N(5)) i5 ();

  assign i4w.en = en;  assign i4w.up_dn = up_dn;  assign i4w.load = load;  assign i4w.load_val = lv[3:0];
  assign i4s.en = en;  assign i4s.up_dn = up_dn;  assign i4s.load = load;  assign i4s.load_val = lv[3:0];
  assign i8.en  = en;  assign i8.up_dn  = up_dn;  assign i8.load  = load;  assign i8.load_val  = lv[7:0];
  assign i5.en  = en;  assign i5.up_dn  = up_dn;  assign i5.load  = load;  assign i5.load_val  = lv[4:0];

  gry_cnt #(.N(4), .WRAP(1'b1)) u_4w (.clk(clk), .rst_n(rst_n), .cnt(i4w));
  gry_cnt #(.N(4), .WRAP(1'b0)) u_4s (.clk(clk), .rst_n(rst_n), .cnt(i4s));
  gry_cnt #(.N(8), .WRAP(1'b1)) u_8  (.clk(clk), .rst_n(rst_n), .cnt(i8));
  gry_cnt #(.N(5), .WRAP(1'b0)) u_5  (.clk(clk), .rst_n(rst_n), .cnt(i5));

  logic [31:0] ob [4];
  logic [31:0] og [4];
  logic        oam [4];
  logic        oan [4];
  logic        ow [4];

  assign ob[0] = 32'(i4w.binary); assign og[0] = 32'(i4w.gray);
  assign ob[1] = 32'(i4s.binary); assign og[1] = 32'(i4s.gray);
  assign ob[2] = 32'(i8.binary);  assign og[2] = 32'(i8.gray);
  assign ob[3] = 32'(i5.binary);  assign og[3] = 32'(i5.gray);
  assign oam[0] = i4w.at_max; assign oan[0] = i4w.at_min; assign ow[0] = i4w.wrap;
  assign oam[1] = i4s.at_max; assign oan[1] = i4s.at_min; assign ow[1] = i4s.wrap;
  assign oam[2] = i8.at_max;  assign oan[2] = i8.at_min;  assign ow[2] = i8.wrap;
  assign oam[3] = i5.at_max;  assign oan[3] = i5.at_min;  assign ow[3] = i5.wrap;

  int    nn [4] = '{4, 4, 8, 5};
  bit    ww [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  string nm [4] = '{"n4w", "n4s", "n8w", "n5s"};
  int    mv [4];
  logic [31:0] pg [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: counter value as an integer in [0, 2^n); out-of-range results wrap or are refused.
  function automatic void model_next(input int n, input bit wrp, input int cur,
                                     input bit ld, input int lval, input bit e, input bit up,
                                     output int nxt, output bit w);
    int span;
    int t;
    span = 1 << n;
    nxt  = cur;
    w    = 1'b0;
    if (ld) begin
      nxt = lval & (span - 1);
    end else if (e) begin
      t = up ? cur + 1 : cur - 1;
      if (t < 0 || t >= span) begin
        if (wrp) begin
          nxt = (t + span) % span;
          w   = 1'b1;
        end
      end else begin
        nxt = t;
      end
    end
  endfunction

  task automatic check_reset_state(input string when_tag);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s %s bin", when_tag, nm[k]), ob[k], 32'd0);
      chk($sformatf("%s %s gray", when_tag, nm[k]), og[k], 32'd0);
      chk($sformatf("%s %s wrap", when_tag, nm[k]), 32'(ow[k]), 32'd0);
      chk($sformatf("%s %s at_min", when_tag, nm[k]), 32'(oan[k]), 32'd1);
      chk($sformatf("%s %s at_max", when_tag, nm[k]), 32'(oam[k]), 32'd0);
      mv[k] = 0;
      pg[k] = '0;
    end
  endtask

  task automatic cyc();
    bit ld_s, e_s, up_s;
    int lv_s;
    int nxt;
    bit w;
    int ex;
    ld_s = load; e_s = en; up_s = up_dn; lv_s = int'(lv);
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      model_next(nn[k], ww[k], mv[k], ld_s, lv_s, e_s, up_s, nxt, w);
      ex = nxt ^ (nxt >> 1);
      chk($sformatf("%s bin", nm[k]), ob[k], 32'(nxt));
      chk($sformatf("%s gray", nm[k]), og[k], 32'(ex));
      chk($sformatf("%s wrap", nm[k]), 32'(ow[k]), 32'(w));
      chk($sformatf("%s at_max", nm[k]), 32'(oam[k]), 32'(nxt == (1 << nn[k]) - 1));
      chk($sformatf("%s at_min", nm[k]), 32'(oan[k]), 32'(nxt == 0));
      if (!ld_s && e_s && nxt != mv[k])
        chk($sformatf("%s gray1bit", nm[k]), 32'($countones(og[k] ^ pg[k])), 32'd1);
      mv[k] = nxt;
      pg[k] = og[k];
    end
  endtask

  initial begin
    logic [3:0] gtab [16];
    gtab = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
             4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

    #12;
    check_reset_state("reset");
    rst_n = 1'b1;
    cyc();
    cyc();

    // Free count up through a full wrap on N=4.
    en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc();
      chk($sformatf("up16 bin[%0d]", i), ob[0], 32'((i + 1) % 16));
      chk($sformatf("up16 gray[%0d]", i), og[0], 32'(gtab[i]));
      chk($sformatf("up16 wrap[%0d]", i), 32'(ow[0]), 32'(i == 15));
    end

    // Load beats a concurrent down step, then down-wrap from 0.
    load = 1'b1; lv = 32'h0; up_dn = 1'b0;
    cyc();
    chk("ld0 bin", ob[0], 32'h0);
    chk("ld0 gray", og[0], 32'h0);
    chk("ld0 wrap", 32'(ow[0]), 32'd0);
    load = 1'b0;
    cyc();
    chk("dnwrap bin", ob[0], 32'hF);
    chk("dnwrap gray", og[0], 32'h8);
    chk("dnwrap wrap", 32'(ow[0]), 32'd1);

    // Saturation at the top for the non-wrapping N=4 instance.
    load = 1'b1; lv = 32'hF;
    cyc();
    load = 1'b0; up_dn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("sat bin[%0d]", i), ob[1], 32'hF);
      chk($sformatf("sat gray[%0d]", i), og[1], 32'h8);
      chk($sformatf("sat at_max[%0d]", i), 32'(oam[1]), 32'd1);
      chk($sformatf("sat wrap[%0d]", i), 32'(ow[1]), 32'd0);
    end

    // Load wins over en; reloading the same value leaves outputs unchanged.
    load = 1'b1; lv = 32'h5;
    cyc();
    chk("ld5 bin", ob[0], 32'h5);
    chk("ld5 gray", og[0], 32'h7);
    cyc();
    chk("ld5 again bin", ob[0], 32'h5);
    chk("ld5 again wrap", 32'(ow[0]), 32'd0);

    // Count to 7, then reset between edges with en still high.
    lv = 32'h0;
    cyc();
    load = 1'b0;
    for (int i = 0; i < 7; i++) cyc();
    chk("pre-rst bin", ob[0], 32'h7);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_state("async rst");
    #1;
    rst_n = 1'b1;
    cyc();
    chk("post-rst bin", ob[0], 32'h1);

    // Random traffic; direction flips rarely so counts reach the range ends.
    for (int i = 0; i < 10000; i++) begin
      int r;
      load = ($urandom_range(0, 19) == 0);
      r = $urandom_range(0, 3);
      lv = (r == 0) ? 32'h0 : (r == 1) ? 32'hFFFF_FFFF : $urandom;
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) up_dn = ~up_dn;
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
